// File: rtl/sram_axi_pkg.sv
// Shared constants and helpers for the sram-like to AXI3 bridge.
// AXI fixed fields, transfer size codes and channel-to-ID mapping.
package sram_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [3:0] CACHE_NONE = 4'd0;
    localparam logic [2:0] PROT_NONE  = 3'd0;
    localparam logic [1:0] LOCK_NONE  = 2'd0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int ID_MAX_W = 8;

    function automatic logic [ID_MAX_W-1:0] ch_id(input int unsigned ch);
        return ch[ID_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sram_arb_fixed.sv
// Fixed-priority one-hot arbiter.
// The lowest set request bit wins.
module sram_arb_fixed #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    // pick the first requester, scanning from index 0
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// NUM_CH sram-like master ports merged onto one AXI3 master.
// Reads may overlap up to MAX_RD; writes run alone.
module sram_axi_bridge
    import sram_axi_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int MAX_RD = 2,
    parameter int ID_W   = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_wr,
    input  logic [2*NUM_CH-1:0]  ch_size,
    input  logic [4*NUM_CH-1:0]  ch_wstrb,
    input  logic [32*NUM_CH-1:0] ch_addr,
    input  logic [32*NUM_CH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]    ch_addr_ok,
    output logic [NUM_CH-1:0]    ch_data_ok,
    output logic [32*NUM_CH-1:0] ch_rdata,
    output logic [ID_W-1:0]      arid,
    output logic [31:0]          araddr,
    output logic [2:0]           arsize,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [7:0]           arlen,
    output logic [1:0]           arburst,
    output logic [1:0]           arlock,
    output logic [3:0]           arcache,
    output logic [2:0]           arprot,
    input  logic [ID_W-1:0]      rid,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [ID_W-1:0]      awid,
    output logic [31:0]          awaddr,
    output logic [2:0]           awsize,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [7:0]           awlen,
    output logic [1:0]           awburst,
    output logic [1:0]           awlock,
    output logic [3:0]           awcache,
    output logic [2:0]           awprot,
    output logic [ID_W-1:0]      wid,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [ID_W-1:0]      bid,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);

    localparam int CNT_W = $clog2(MAX_RD + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             live_q;
    logic [CNT_W-1:0] rd_cnt;
    logic             wr_pend;
    logic             ar_v_q, aw_v_q, w_v_q;
    logic [ID_W-1:0]  ar_id_q, aw_id_q;
    logic [31:0]      ar_addr_q, aw_addr_q, w_data_q;
    logic [1:0]       ar_size_q, aw_size_q;
    logic [3:0]       w_strb_q;
    logic [31:0]      rdata_q [NUM_CH];

    logic              r_hit, b_hit, wr_busy, rd_room, wr_room;
    logic [NUM_CH-1:0] elig, gnt;
    logic [IDX_W-1:0]  sel;
    logic              rd_go, wr_go;
    logic              unused_in;

    assign unused_in = ^{rresp, rlast, bresp};

    assign r_hit   = rvalid & live_q;
    assign b_hit   = bvalid & live_q;
    assign wr_busy = wr_pend & ~b_hit;

    // a retiring R beat or B response frees its slot in the same cycle
    assign rd_room = live_q & ~ar_v_q & ~wr_busy &
                     ((rd_cnt < CNT_W'(MAX_RD)) | r_hit);
    assign wr_room = live_q & ~aw_v_q & ~w_v_q & ~wr_busy &
                     ((rd_cnt == '0) | ((rd_cnt == CNT_W'(1)) & r_hit));

    // a channel competes only if its request type can be taken now
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++)
            elig[i] = ch_req[i] & (ch_wr[i] ? wr_room : rd_room);
    end

    sram_arb_fixed #(.N(NUM_CH)) u_arb (
        .req (elig),
        .gnt (gnt)
    );

    // encode the one-hot grant into a channel index
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (gnt[i]) sel = i[IDX_W-1:0];
    end

    assign ch_addr_ok = gnt;
    assign rd_go      = (|gnt) & ~ch_wr[sel];
    assign wr_go      = (|gnt) & ch_wr[sel];

    // rready/bready come up one cycle after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) live_q <= 1'b0;
        else         live_q <= 1'b1;
    end

    // outstanding reads: queued in AR plus in flight on the bus
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt <= '0;
        end else begin
            case ({rd_go, r_hit})
                2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
                2'b01:   rd_cnt <= rd_cnt - CNT_W'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    // AR holding register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_v_q    <= 1'b0;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
        end else if (rd_go) begin
            ar_v_q    <= 1'b1;
            ar_id_q   <= ID_W'(ch_id(32'(sel)));
            ar_addr_q <= ch_addr[32*sel +: 32];
            ar_size_q <= ch_size[2*sel +: 2];
        end else if (arready) begin
            ar_v_q    <= 1'b0;
        end
    end

    // AW and W holding registers plus write-pending flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_v_q    <= 1'b0;
            w_v_q     <= 1'b0;
            wr_pend   <= 1'b0;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (awready) aw_v_q <= 1'b0;
            if (wready)  w_v_q  <= 1'b0;
            if (b_hit)   wr_pend <= 1'b0;
            if (wr_go) begin
                aw_v_q    <= 1'b1;
                w_v_q     <= 1'b1;
                wr_pend   <= 1'b1;
                aw_id_q   <= ID_W'(ch_id(32'(sel)));
                aw_addr_q <= ch_addr[32*sel +: 32];
                aw_size_q <= ch_size[2*sel +: 2];
                w_data_q  <= ch_wdata[32*sel +: 32];
                w_strb_q  <= ch_wstrb[4*sel +: 4];
            end
        end
    end

    // per-channel read data hold for cycles without a matching beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) rdata_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (r_hit && rid == ID_W'(i)) rdata_q[i] <= rdata;
        end
    end

    // route R and B responses back by ID; unknown IDs are dropped
    always_comb begin
        ch_data_ok = '0;
        ch_rdata   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data_ok[i] = (r_hit && rid == ID_W'(i)) ||
                            (b_hit && bid == ID_W'(i));
            ch_rdata[32*i +: 32] = (r_hit && rid == ID_W'(i)) ?
                                   rdata : rdata_q[i];
        end
    end

    assign rready  = live_q;
    assign bready  = live_q;

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = {1'b0, ar_size_q};
    assign arvalid = ar_v_q;
    assign arlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign arlock  = LOCK_NONE;
    assign arcache = CACHE_NONE;
    assign arprot  = PROT_NONE;

    assign awid    = aw_id_q;
    assign awaddr  = aw_addr_q;
    assign awsize  = {1'b0, aw_size_q};
    assign awvalid = aw_v_q;
    assign awlen   = LEN_SINGLE;
    assign awburst = BURST_INCR;
    assign awlock  = LOCK_NONE;
    assign awcache = CACHE_NONE;
    assign awprot  = PROT_NONE;

    assign wid     = aw_id_q;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = w_v_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a hand-driven AXI slave.
// Two channels, two outstanding reads, 4-bit IDs.
module tb_sram_axi_bridge;

    logic        clk, resetn;
    logic [1:0]  ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [3:0]  ch_size;
    logic [7:0]  ch_wstrb;
    logic [63:0] ch_addr, ch_wdata, ch_rdata;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;

    int n_run  = 0;
    int n_fail = 0;

    sram_axi_bridge #(.NUM_CH(2), .MAX_RD(2), .ID_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
        .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
        .ch_rdata(ch_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize),
        .arvalid(arvalid), .arready(arready), .arlen(arlen),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize),
        .awvalid(awvalid), .awready(awready), .awlen(awlen),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_req(input int ch, input logic [31:0] a);
        ch_req[ch]          = 1'b1;
        ch_wr[ch]           = 1'b0;
        ch_size[2*ch +: 2]  = 2'd2;
        ch_addr[32*ch +: 32] = a;
    endtask

    // hold the request until addr_ok, bounded
    task automatic wait_ok(input int ch, input string tag);
        int n = 0;
        #1;
        while (!ch_addr_ok[ch] && n < 20) begin
            step();
            #1;
            n++;
        end
        check(tag, 64'(ch_addr_ok[ch]), 64'd1);
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
    endtask

    initial begin
        resetn = 1'b0;
        ch_req = 2'b11; ch_wr = '0; ch_size = '0; ch_wstrb = '0;
        ch_addr = '0; ch_wdata = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
        #3;
        check("rst_addr_ok", 64'(ch_addr_ok), 64'd0);
        check("rst_valids",
              64'({arvalid, awvalid, wvalid}), 64'd0);
        check("rst_ready", 64'({rready, bready}), 64'd0);
        step();
        ch_req = '0;
        resetn = 1'b1;
        step();
        #1;
        check("live_ready", 64'({rready, bready}), 64'b11);
        check("const_ar",
              64'({arlen, arburst, arlock, arcache, arprot}),
              64'({8'd0, 2'b01, 2'd0, 4'd0, 3'd0}));

        // single read on ch1
        arready = 1'b1;
        rd_req(1, 32'h1FC0_0000);
        #1;
        check("t1_addr_ok", 64'(ch_addr_ok), 64'b10);
        step();
        ch_req = '0;
        #1;
        check("t1_ar", 64'({arvalid, arid, arsize, araddr}),
              64'({1'b1, 4'd1, 3'd2, 32'h1FC0_0000}));
        check("t1_cnt1", 64'(dut.rd_cnt), 64'd1);
        step();
        #1;
        check("t1_ar_drop", 64'(arvalid), 64'd0);
        step();
        step();
        r_beat(4'd1, 32'h3C08_BFAF);
        #1;
        check("t1_data_ok", 64'(ch_data_ok), 64'b10);
        check("t1_rdata", 64'(ch_rdata[63:32]), 64'h3C08_BFAF);
        step();
        rvalid = 1'b0;
        #1;
        check("t1_cnt0", 64'(dut.rd_cnt), 64'd0);
        check("t1_hold", 64'({ch_data_ok, ch_rdata[63:32]}),
              64'({2'b00, 32'h3C08_BFAF}));

        // priority and out-of-order return by ID
        step();
        rd_req(0, 32'h0000_0100);
        rd_req(1, 32'h0000_0200);
        #1;
        check("t2_first", 64'(ch_addr_ok), 64'b01);
        step();
        ch_req[0] = 1'b0;
        #1;
        check("t2_arid0", 64'({arvalid, arid, araddr}),
              64'({1'b1, 4'd0, 32'h0000_0100}));
        wait_ok(1, "t2_ok1");
        step();
        ch_req[1] = 1'b0;
        #1;
        check("t2_arid1", 64'({arvalid, arid, araddr}),
              64'({1'b1, 4'd1, 32'h0000_0200}));
        step();
        r_beat(4'd1, 32'h1111_1111);
        #1;
        check("t2_r1", 64'({ch_data_ok, ch_rdata[63:32]}),
              64'({2'b10, 32'h1111_1111}));
        step();
        r_beat(4'd0, 32'h2222_2222);
        #1;
        check("t2_r0", 64'({ch_data_ok, ch_rdata[31:0]}),
              64'({2'b01, 32'h2222_2222}));
        check("t2_r1_hold", 64'(ch_rdata[63:32]), 64'h1111_1111);
        step();
        rvalid = 1'b0;
        #1;
        check("t2_cnt0", 64'(dut.rd_cnt), 64'd0);

        // outstanding limit
        rd_req(0, 32'h0000_1000);
        wait_ok(0, "t3_ok_a");
        step();
        ch_req[0] = 1'b0;
        #1;
        ch_addr[31:0] = 32'h0000_1004;
        ch_req[0] = 1'b1;
        wait_ok(0, "t3_ok_b");
        step();
        ch_req[0] = 1'b0;
        rd_req(1, 32'h0000_2000);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_stall", 64'({ch_addr_ok, dut.rd_cnt}),
                  64'({2'b00, 2'd2}));
            step();
        end
        r_beat(4'd0, 32'hAAAA_0001);
        #1;
        check("t3_grant_in_r", 64'({ch_addr_ok, ch_data_ok}),
              64'({2'b10, 2'b01}));
        step();
        rvalid = 1'b0;
        ch_req[1] = 1'b0;
        #1;
        check("t3_cnt_held", 64'(dut.rd_cnt), 64'd2);
        step();
        r_beat(4'd0, 32'hAAAA_0002);
        step();
        r_beat(4'd1, 32'hBBBB_0001);
        #1;
        check("t3_r_third", 64'({ch_data_ok, ch_rdata[63:32]}),
              64'({2'b10, 32'hBBBB_0001}));
        step();
        rvalid = 1'b0;
        #1;
        check("t3_cnt0", 64'(dut.rd_cnt), 64'd0);

        // write serialized behind an outstanding read
        rd_req(1, 32'h0000_3000);
        wait_ok(1, "t4_rd_ok");
        step();
        ch_req[1] = 1'b0;
        step();
        ch_req[0] = 1'b1;
        ch_wr[0] = 1'b1;
        ch_size[1:0] = 2'd2;
        ch_addr[31:0] = 32'h0000_0100;
        ch_wdata[31:0] = 32'hDEAD_BEEF;
        ch_wstrb[3:0] = 4'b0011;
        wready = 1'b1;
        awready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t4_wr_stall", 64'(ch_addr_ok), 64'd0);
            step();
        end
        r_beat(4'd1, 32'hCCCC_0001);
        wait_ok(0, "t4_wr_ok");
        step();
        rvalid = 1'b0;
        ch_req[0] = 1'b0;
        ch_wr[0] = 1'b0;
        #1;
        check("t4_aw_w", 64'({awvalid, wvalid, awid, wid, wlast}),
              64'({1'b1, 1'b1, 4'd0, 4'd0, 1'b1}));
        check("t4_awaddr", 64'({awaddr, awsize}),
              64'({32'h0000_0100, 3'd2}));
        check("t4_wdata", 64'({wdata, wstrb}),
              64'({32'hDEAD_BEEF, 4'b0011}));
        step();
        #1;
        check("t4_w_drop", 64'({awvalid, wvalid}), 64'b10);
        // read-behind-write: ch1 waits for the B response
        rd_req(1, 32'h0000_4000);
        step();
        awready = 1'b1;
        #1;
        check("t4_aw_hold", 64'({awvalid, ch_addr_ok}),
              64'({1'b1, 2'b00}));
        step();
        awready = 1'b0;
        #1;
        check("t4_aw_drop", 64'({awvalid, wvalid}), 64'b00);
        check("t5_blocked", 64'(ch_addr_ok), 64'd0);
        step();
        #1;
        check("t5_blocked2", 64'(ch_addr_ok), 64'd0);
        bvalid = 1'b1;
        bid = 4'd0;
        #1;
        check("t5_b_cycle", 64'({ch_data_ok, ch_addr_ok}),
              64'({2'b01, 2'b10}));
        step();
        bvalid = 1'b0;
        ch_req[1] = 1'b0;
        #1;
        check("t5_ar_next", 64'({arvalid, arid, araddr, ch_data_ok}),
              64'({1'b1, 4'd1, 32'h0000_4000, 2'b00}));
        step();
        r_beat(4'd1, 32'hDDDD_0001);
        step();
        rvalid = 1'b0;
        #1;
        check("t5_cnt0", 64'(dut.rd_cnt), 64'd0);

        // reset in the middle of a read
        arready = 1'b0;
        rd_req(0, 32'h0000_5000);
        wait_ok(0, "t6_ok");
        step();
        ch_req[0] = 1'b0;
        #1;
        check("t6_pre", 64'({arvalid, dut.rd_cnt}),
              64'({1'b1, 2'd1}));
        resetn = 1'b0;
        r_beat(4'd0, 32'hEEEE_0001);
        #1;
        check("t6_async", 64'({arvalid, awvalid, wvalid, rready,
                               bready, ch_data_ok}), 64'd0);
        step();
        rvalid = 1'b0;
        resetn = 1'b1;
        step();
        #1;
        check("t6_after", 64'({dut.rd_cnt, arvalid, rready}),
              64'({2'd0, 1'b0, 1'b1}));
        arready = 1'b1;
        rd_req(1, 32'h0000_6000);
        wait_ok(1, "t6_ok2");
        step();
        ch_req[1] = 1'b0;
        #1;
        check("t6_ar", 64'({arvalid, arid, araddr}),
              64'({1'b1, 4'd1, 32'h0000_6000}));
        step();
        r_beat(4'd1, 32'h1234_5678);
        #1;
        check("t6_r", 64'({ch_data_ok, ch_rdata[63:32]}),
              64'({2'b10, 32'h1234_5678}));
        step();
        rvalid = 1'b0;
        #1;
        check("t6_cnt0", 64'(dut.rd_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
